// File: rtl/pwm_decoder.sv
// pwm_decoder: samples a 1-bit PWM stream and measures each frame between
// successive rising edges. It reports the high-cycle count (saturated to
// 2^WIDTH-1) and the period over a one-entry valid/ready output buffer. A line
// with no rising edge for TIMEOUT cycles is flagged as stuck.
//
// Optional build macro: PWM_DECODER_GLITCH_FILTER_EN inserts a 3-tap majority
// filter after the synchronizer. The filter rejects single-cycle pulses and
// adds 2 cycles of latency.
//
// Parameters:
//   WIDTH   (1..16)      sample width
//   TIMEOUT (2..65535)   cycles without a rising edge before stuck
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   en_i             decoder enable (0 holds the measurement side in IDLE)
//   pwm_in_i         asynchronous PWM input
//   sample_o         high-cycle count of the last completed frame
//   period_o         cycle length of the last completed frame
//   sample_valid_o   sample_o/period_o hold an unconsumed result
//   sample_ready_i   consumer accepts on sample_valid_o && sample_ready_i
//   stuck_o          no rising edge seen for TIMEOUT cycles
//   overrun_o        sticky: an unconsumed result was overwritten
module pwm_decoder #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             pwm_in_i,
  output logic [WIDTH-1:0] sample_o,
  output logic [15:0]      period_o,
  output logic             sample_valid_o,
  input  logic             sample_ready_i,
  output logic             stuck_o,
  output logic             overrun_o
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   SAMPLE_MAX = (17'd1 << WIDTH) - 17'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STUCK   = 2'd2
  } state_e;

  // Input synchronizer and edge detect
  logic sync1_q, sync2_q, pwm_d_q;
  logic pwm_s;
  logic rise;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      pwm_d_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in_i;
      sync2_q <= sync1_q;
      pwm_d_q <= pwm_s;
    end
  end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  // Majority of three consecutive synchronized samples, registered
  logic tap1_q, tap2_q, maj_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tap1_q <= 1'b0;
      tap2_q <= 1'b0;
      maj_q  <= 1'b0;
    end else begin
      tap1_q <= sync2_q;
      tap2_q <= tap1_q;
      maj_q  <= (sync2_q & tap1_q) | (sync2_q & tap2_q) | (tap1_q & tap2_q);
    end
  end

  assign pwm_s = maj_q;
`else
  assign pwm_s = sync2_q;
`endif

  assign rise = pwm_s & ~pwm_d_q;

  // Measurement state and counters
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]     hi_cnt_q, hi_cnt_d;
  logic                 stuck_q, stuck_d;
  logic [CNT_W-1:0]     per_inc, hi_inc;
  logic [WIDTH-1:0]     hi_sat;
  logic                 timeout_hit;

  // Emit request toward the output buffer
  logic                 emit;
  logic [WIDTH-1:0]     emit_sample;
  logic [CNT_W-1:0]     emit_period;

  // Output buffer
  logic [WIDTH-1:0]     sample_q, sample_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  assign per_inc     = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_W'(1);
  assign hi_inc      = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + CNT_W'(pwm_s);
  assign hi_sat      = ({1'b0, hi_cnt_q} > SAMPLE_MAX) ? {WIDTH{1'b1}} : WIDTH'(hi_cnt_q);
  assign timeout_hit = (per_inc >= TIMEOUT_C);

  // Next-state: frame measurement and stuck detection
  always_comb begin
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    hi_cnt_d    = hi_cnt_q;
    stuck_d     = stuck_q;
    emit        = 1'b0;
    emit_sample = '0;
    emit_period = '0;

    if (!en_i) begin
      state_d   = ST_IDLE;
      per_cnt_d = '0;
      hi_cnt_d  = '0;
      stuck_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            // First edge only opens a frame; nothing to report yet
            state_d   = ST_MEASURE;
            per_cnt_d = CNT_W'(1);
            hi_cnt_d  = CNT_W'(1);
          end else if (timeout_hit) begin
            state_d     = ST_STUCK;
            per_cnt_d   = per_inc;
            stuck_d     = 1'b1;
            emit        = 1'b1;
            emit_sample = pwm_s ? {WIDTH{1'b1}} : '0;
          end else begin
            per_cnt_d = per_inc;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            // Edge cycle closes the old frame and is counted in the new one
            emit        = 1'b1;
            emit_sample = hi_sat;
            emit_period = per_cnt_q;
            per_cnt_d   = CNT_W'(1);
            hi_cnt_d    = CNT_W'(1);
          end else if (timeout_hit) begin
            state_d     = ST_STUCK;
            per_cnt_d   = per_inc;
            stuck_d     = 1'b1;
            emit        = 1'b1;
            emit_sample = pwm_s ? {WIDTH{1'b1}} : '0;
          end else begin
            per_cnt_d = per_inc;
            hi_cnt_d  = hi_inc;
          end
        end
        ST_STUCK: begin
          if (rise) begin
            state_d   = ST_MEASURE;
            per_cnt_d = CNT_W'(1);
            hi_cnt_d  = CNT_W'(1);
            stuck_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Next-state: one-entry output buffer with overwrite-on-full
  always_comb begin
    sample_d  = sample_q;
    period_d  = period_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (emit) begin
      sample_d = emit_sample;
      period_d = emit_period;
      valid_d  = 1'b1;
      if (valid_q && !sample_ready_i) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && sample_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      stuck_q   <= 1'b0;
      sample_q  <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      stuck_q   <= stuck_d;
      sample_q  <= sample_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_o       = sample_q;
  assign period_o       = period_q;
  assign sample_valid_o = valid_q;
  assign stuck_o        = stuck_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: drives PWM frames described as (high, period) pairs. A
// frame-level model queues the expected (sample, period) results, and a
// monitor pops and compares them on every output handshake.
module tb_pwm_decoder;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 1024;
  localparam int          SAT     = 255;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int          LAT     = 5;
`else
  localparam int          LAT     = 3;
`endif

  typedef struct {
    int sample;
    int period;
  } res_t;

  logic             clk;
  logic             rst;
  logic             en;
  logic             pwm;
  logic [WIDTH-1:0] sample;
  logic [15:0]      period;
  logic             sample_valid;
  logic             sample_ready;
  logic             stuck;
  logic             overrun;

  res_t exp_q[$];
  res_t mon_e;
  int   checks;
  int   failures;
  int   started;
  int   prev_h;
  int   prev_p;
  int   rdy_mode;
  logic rdy_force;
  int   rdy_low;

  pwm_decoder #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .pwm_in_i       (pwm),
    .sample_o       (sample),
    .period_o       (period),
    .sample_valid_o (sample_valid),
    .sample_ready_i (sample_ready),
    .stuck_o        (stuck),
    .overrun_o      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_force(input logic v);
    #1 rdy_force = v;
  endtask

  // A rising edge closes the previous frame (if one is open) and opens a new one
  task automatic model_edge(input int h, input int p);
    res_t r;
    if (started != 0) begin
      r.sample = (prev_h > SAT) ? SAT : prev_h;
      r.period = prev_p;
      exp_q.push_back(r);
    end
    prev_h  = h;
    prev_p  = p;
    started = 1;
  endtask

  task automatic frame(input int h, input int p, input int pulse_at);
    for (int i = 0; i < p; i++) begin
      tick();
      pwm = (i < h);
      if (i == 0) model_edge(h, p);
      if (pulse_at >= 0 && i == pulse_at) set_force(1'b1);
      if (pulse_at >= 0 && i == pulse_at + 1) set_force(1'b0);
    end
  endtask

  // Frame with a one-cycle high pulse at offset g inside the low phase
  task automatic frame_glitch(input int h, input int p, input int g);
    for (int i = 0; i < p; i++) begin
      tick();
      pwm = (i < h) || (i == g);
`ifdef PWM_DECODER_GLITCH_FILTER_EN
      if (i == 0) model_edge(h, p);
`else
      if (i == 0) model_edge(h, g);
      if (i == g) model_edge(1, p - g);
`endif
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    exp_q.delete();
    started = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    chk(name, exp_q.size(), 0);
  endtask

  // Consumer: either a forced level or random with at most 3 low cycles in a row
  initial begin
    sample_ready = 1'b0;
    rdy_low      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode != 0) begin
        if (rdy_low >= 3 || $urandom_range(0, 1) == 1) begin
          sample_ready = 1'b1;
          rdy_low      = 0;
        end else begin
          sample_ready = 1'b0;
          rdy_low++;
        end
      end else begin
        sample_ready = rdy_force;
      end
    end
  end

  // Monitor: every handshake must match the oldest expected result
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual sample=%0d period=%0d required none",
                   sample, period);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sample", int'(sample), mon_e.sample);
          chk("period", int'(period), mon_e.period);
        end
      end
    end
  end

  initial begin
    int h;
    int p;
    checks    = 0;
    failures  = 0;
    started   = 0;
    prev_h    = 0;
    prev_p    = 0;
    rdy_mode  = 0;
    rdy_force = 1'b0;
    rst       = 1'b1;
    en        = 1'b1;
    pwm       = 1'b0;

    repeat (3) tick();
    chk("rst_sample", int'(sample), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_stuck", int'(stuck), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b0;

    // Pending result consumed in the same cycle a new one is emitted
    frame(10, 50, -1);
    frame(15, 50, -1);
    frame(20, 50, LAT - 2);
    chk("coinc_valid", int'(sample_valid), 1);
    chk("coinc_sample", int'(sample), 15);
    chk("coinc_period", int'(period), 50);
    chk("coinc_overrun", int'(overrun), 0);

    rdy_mode = 1;
    repeat (4) frame(64, 256, -1);
    frame(300, 400, -1);
    frame(100, 200, -1);
    frame_glitch(32, 128, 70);
    frame(32, 128, -1);

    repeat (40) begin
      p = int'($urandom_range(6, 600));
      h = int'($urandom_range(2, p - 2));
      frame(h, p, -1);
    end

    // Disabling discards the open frame; the buffer keeps draining
    repeat (3) tick();
    en      = 1'b0;
    started = 0;
    repeat (10) tick();
    chk("dis_stuck", int'(stuck), 0);
    en = 1'b1;
    frame(50, 150, -1);
    frame(70, 150, -1);
    frame(30, 100, -1);
    frame(30, 100, -1);

    // Line held high well past TIMEOUT: one stuck result (all-ones, period 0)
    for (int i = 0; i < 1100; i++) begin
      tick();
      pwm = 1'b1;
      if (i == 0) begin
        model_edge(0, 0);
        exp_q.push_back('{SAT, 0});
        started = 0;
      end
    end
    chk("stuck_set", int'(stuck), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      pwm = 1'b0;
    end
    chk("stuck_hold", int'(stuck), 1);
    repeat (3) frame(40, 120, -1);
    chk("stuck_clear", int'(stuck), 0);
    drain("drain_main");
    chk("no_overrun", int'(overrun), 0);

    // Overwrite of an unconsumed result
    rdy_mode  = 0;
    rdy_force = 1'b0;
    do_reset();
    rst = 1'b0;
    frame(10, 100, -1);
    frame(20, 100, -1);
    frame(30, 100, -1);
    exp_q.delete(exp_q.size() - 2);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_sample", int'(sample), 20);
    chk("ovr_period", int'(period), 100);
    chk("ovr_valid", int'(sample_valid), 1);
    set_force(1'b1);
    repeat (3) tick();
    set_force(1'b0);
    chk("ovr_valid_drop", int'(sample_valid), 0);
    chk("ovr_sticky", int'(overrun), 1);
    chk("ovr_q_empty", exp_q.size(), 0);

    do_reset();
    chk("rst2_overrun", int'(overrun), 0);
    chk("rst2_valid", int'(sample_valid), 0);
    chk("rst2_sample", int'(sample), 0);
    rst = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Receive-side counterpart to the audio PWM generator. Samples a 1-bit PWM stream (the board `aud_pwm` net looped back, or an external PWM source), measures high time and period of each frame between successive rising edges, and emits one duty sample per frame over a valid/ready handshake. Used for on-board loopback checking of the audio path and as a PWM-to-PCM front end. Sits in the `clk_nes` domain next to the tone/APU audio logic.

## Interface
- `WIDTH`, 8: sample width; sample = high-cycle count saturated to 2^WIDTH-1.
- `TIMEOUT`, 1024: cycles without a rising edge before declaring the line stuck (range 2..65535).

- `clk`  in  1  system clock (`clk_nes`).
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  decoder enable.
- `pwm_in`  in  1  asynchronous PWM input.
- `sample`  out  WIDTH  high-cycle count of the last completed frame.
- `period`  out  16  cycle length of the last completed frame.
- `sample_valid`  out  1  `sample`/`period` hold an unconsumed result.
- `sample_ready`  in  1  consumer accepts on `sample_valid && sample_ready`.
- `stuck`  out  1  no rising edge for `TIMEOUT` cycles.
- `overrun`  out  1  sticky: an unconsumed result was overwritten.

## Operation
- Input path: 2-flop synchronizer → `pwm_s`; `pwm_d` = `pwm_s` delayed 1; `edge` = `pwm_s & ~pwm_d`.
- 16-bit counters `per_cnt`, `hi_cnt`, both saturating at 0xFFFF.
- States:
  - IDLE (after reset or `en`=0): `per_cnt` increments each cycle; `edge` → MEASURE with `per_cnt`=1, `hi_cnt`=1, no sample emitted; `per_cnt` reaching `TIMEOUT` → STUCK.
  - MEASURE: non-edge cycle: `per_cnt`+1, `hi_cnt`+`pwm_s`. Edge cycle: emit (`sample`=min(`hi_cnt`,2^WIDTH-1), `period`=`per_cnt`), reload counters to 1/1. The edge cycle belongs to the new frame. `per_cnt` reaching `TIMEOUT` → STUCK.
  - STUCK: `stuck`=1; on entry emit one result: `sample`=`pwm_s`?2^WIDTH-1:0, `period`=0. `edge` → MEASURE (counters 1/1, `stuck`=0, no emit). No further emits while in STUCK.
- `en`=0: state forced to IDLE, counters cleared, `stuck` cleared; output buffer and `overrun` untouched, handshake keeps working.
- Output buffer, one entry:
  - Emit with buffer empty or being consumed the same cycle → load, `sample_valid`=1, no overrun.
  - Emit with `sample_valid && !sample_ready` → overwrite with the new result, set `overrun`.
  - Consume without emit → `sample_valid`=0; `sample`/`period` hold their last values.
- `overrun` clears only on `rst`.

## Timing
- Reset values: `sample`=0, `period`=0, `sample_valid`=0, `stuck`=0, `overrun`=0, state IDLE, sync flops 0.
- Latency: `pwm_in` high at clk edge N → `edge` in cycle N+2 → `sample_valid` high from edge N+3.
- Throughput: one result per frame; minimum frame is 2 cycles.
- `stuck` rises the same cycle the STUCK emit appears in the buffer.
- `rst` mid-frame discards the partial frame and any buffered result.

## Configuration
- `PWM_DECODER_GLITCH_FILTER_EN`: when defined, a 3-tap majority filter sits between the synchronizer and `pwm_s`. Single-cycle pulses are rejected and latency grows by 2 cycles (`sample_valid` at N+5). When undefined, `pwm_s` is the second sync flop directly.

## Test plan
- Period 256, high 64, 4 frames → first frame after reset not emitted; following results `sample`=64, `period`=256.
- High 300 of period 400, `WIDTH`=8 → `sample`=255 (saturated), `period`=400.
- `pwm_in` held high 1100 cycles after a valid frame → `stuck`=1 with one result `sample`=255, `period`=0; next rising edge → `stuck`=0, and the following frame decodes normally.
- `sample_ready`=0 across two frames (high 10, then high 20, period 100) → `sample`=20, `overrun`=1; raise `sample_ready` → `sample_valid` drops after one handshake; `overrun` stays 1 until `rst`.
- Emit coincident with `sample_ready`=1 on a pending result → old value consumed, new value loaded, `sample_valid` stays 1, `overrun`=0.
- Filter build: 1-cycle high glitch inside a low phase (period 128, high 32) → results unchanged (32/128); without the macro the glitch causes an extra frame boundary.
